muldiv_unit: RTL and testbench

Iterative integer multiply/divide unit with architectural HI/LO registers, parametrised in operand width, adding MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO to the pipelined MIPS core. It sits beside the ALU in the X stage. Operations are issued from X with a start strobe. A combinational stall output freezes IF/ID and bubbles ID→X while an operation is in flight. Multiply and divide each take WIDTH+1 cycles, one bit per cycle.

---
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide: one bit per cycle, WIDTH RUN cycles + 1 FIN cycle.
// No backpressure input; stall asks the pipeline to hold any op that arrives while busy.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;
  localparam logic [2:0] OP_MFHI = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   dsr;
  logic [WIDTH-1:0]   a_orig;
  logic               neg_p;
  logic               neg_r;
  logic               is_div;
  logic               dz;

  logic               sgn_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign stall   = start & busy;
  assign rd_data = (op == OP_MFHI) ? hi : lo;

  assign sgn_op = ~op[0];
  assign a_mag  = (sgn_op && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (sgn_op && b[WIDTH-1]) ? -b : b;

  // Multiply: {rem, q} acts as the product register, shifted right each step.
  assign mul_sum = rem + {1'b0, dsr & {WIDTH{q[0]}}};

  // Divide: restoring step; borrow out of the wide subtract means restore.
  assign div_shift = {rem[WIDTH-1:0], q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, dsr};

  assign prod_raw = {rem[WIDTH-1:0], q};
  assign prod_fix = neg_p ? -prod_raw : prod_raw;
  assign quo_fix  = neg_p ? -q : q;
  assign rem_fix  = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
      q      <= '0;
      dsr    <= '0;
      a_orig <= '0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (en) begin
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !busy) begin
              if (!op[2]) begin
                state  <= RUN;
                busy   <= 1'b1;
                cnt    <= CNT_W'(WIDTH - 1);
                rem    <= '0;
                dsr    <= op[1] ? b_mag : a_mag;
                q      <= op[1] ? a_mag : b_mag;
                a_orig <= a;
                neg_p  <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= sgn_op & a[WIDTH-1];
                is_div <= op[1];
                dz     <= op[1] & (b == '0);
              end else if (op == OP_MTHI) begin
                hi <= a;
              end else if (op == OP_MTLO) begin
                lo <= a;
              end
            end
          end
          RUN: begin
            if (is_div) begin
              rem <= div_diff[WIDTH+1] ? div_shift : div_diff[WIDTH:0];
              q   <= {q[WIDTH-2:0], ~div_diff[WIDTH+1]};
            end else begin
              rem <= {1'b0, mul_sum[WIDTH:1]};
              q   <= {mul_sum[0], q[WIDTH-1:1]};
            end
            if (cnt == '0) state <= FIN;
            else           cnt   <= cnt - 1'b1;
          end
          FIN: begin
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (dz) begin
              hi <= a_orig;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit instance and an 8-bit instance share one clock.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, start, flush, stall, busy;
  logic [2:0]  op;
  logic [31:0] a, b, rd_data, hi, lo;
  logic        en8, start8, flush8, stall8, busy8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, rd8, hi8, lo8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .stall(stall), .busy(busy), .rd_data(rd_data), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .start(start8), .op(op8), .a(a8), .b(b8),
    .flush(flush8), .stall(stall8), .busy(busy8), .rd_data(rd8), .hi(hi8), .lo(lo8)
  );

  task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int cyc);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      input int gap_at, output int cyc);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0;
    while (busy8 && cyc < 200) begin
      cyc++;
      if (gap_at != 0 && cyc == gap_at)     en8 = 1'b0;
      if (gap_at != 0 && cyc == gap_at + 5) en8 = 1'b1;
      @(negedge clk);
    end
    en8 = 1'b1;
  endtask

  task automatic test_reset;
    start = 1'b1; op = 3'd6;
    #3;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", lo); end
    n_cmp++; if (hi8 !== 8'h0 || lo8 !== 8'h0) begin n_bad++; $display("FAIL reset_w8 got %h/%h want 0/0", hi8, lo8); end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // op, a, b, expected hi, expected lo
  task automatic test_arith;
    logic [2:0]  vo [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2};
    logic [31:0] va [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000,
                            32'd7, 32'd7, 32'd5, 32'hFFFFFFFB};
    logic [31:0] vb [8] = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF,
                            32'd2, 32'hFFFFFFFE, 32'd0, 32'd0};
    logic [31:0] vh [8] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0,
                            32'd1, 32'd1, 32'd5, 32'hFFFFFFFB};
    logic [31:0] vl [8] = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'h80000000,
                            32'd3, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF};
    int cyc;
    for (int i = 0; i < 8; i++) begin
      run32(vo[i], va[i], vb[i], cyc);
      n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL arith%0d_cycles got %0d want 33", i, cyc); end
      n_cmp++; if (hi !== vh[i]) begin n_bad++; $display("FAIL arith%0d_hi got %h want %h", i, hi, vh[i]); end
      n_cmp++; if (lo !== vl[i]) begin n_bad++; $display("FAIL arith%0d_lo got %h want %h", i, lo, vl[i]); end
    end
    op = 3'd6; #1;
    n_cmp++; if (rd_data !== 32'hFFFFFFFB) begin n_bad++; $display("FAIL mfhi_rd got %h want fffffffb", rd_data); end
    op = 3'd7; #1;
    n_cmp++; if (rd_data !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mflo_rd got %h want ffffffff", rd_data); end
  endtask

  task automatic test_stall;
    int cnt;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h00010000; b = 32'h00010000;
    @(negedge clk);
    op = 3'd6; a = 32'h0; b = 32'h0;
    cnt = 0;
    while (stall && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    n_cmp++; if (cnt !== 33) begin n_bad++; $display("FAIL stall_cycles got %0d want 33", cnt); end
    n_cmp++; if (rd_data !== 32'h1) begin n_bad++; $display("FAIL stall_mfhi_rd got %h want 1", rd_data); end
    n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL stall_lo got %h want 0", lo); end
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mfhi_no_busy got %b want 0", busy); end
  endtask

  task automatic test_mt;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0; op = 3'd6;
    #1;
    n_cmp++; if (rd_data !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mthi_rd got %h want cafef00d", rd_data); end
  endtask

  task automatic test_flush;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; op = 3'd5; a = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (lo !== 32'h1234) begin n_bad++; $display("FAIL mtlo got %h want 1234", lo); end
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got %b want 0", busy); end
    n_cmp++; if (hi !== 32'h0 || lo !== 32'h1234) begin n_bad++; $display("FAIL flush_hilo got %h/%h want 0/1234", hi, lo); end
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'hBEEF;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL flush_start_ignored got %h want 0", hi); end
    repeat (40) @(negedge clk);
    n_cmp++; if (lo !== 32'h1234 || busy !== 1'b0) begin n_bad++; $display("FAIL flush_no_late_write got %h busy %b want 1234 busy 0", lo, busy); end
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h55;
    @(negedge clk);
    op = 3'd1; a = 32'h1234; b = 32'h10;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_bad++; $display("FAIL rst_mid_hilo got %h/%h want 0/0", hi, lo); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++; if (lo !== 32'h0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_write got %h busy %b want 0 busy 0", lo, busy); end
  endtask

  task automatic test_w8;
    int cyc;
    run8(3'd0, 8'h80, 8'h80, 0, cyc);
    n_cmp++; if (cyc !== 9) begin n_bad++; $display("FAIL w8_cycles got %0d want 9", cyc); end
    n_cmp++; if (hi8 !== 8'h40 || lo8 !== 8'h00) begin n_bad++; $display("FAIL w8_mult got %h/%h want 40/00", hi8, lo8); end
    run8(3'd3, 8'hFF, 8'h10, 0, cyc);
    n_cmp++; if (hi8 !== 8'h0F || lo8 !== 8'h0F) begin n_bad++; $display("FAIL w8_divu got %h/%h want 0f/0f", hi8, lo8); end
    run8(3'd5, 8'h55, 8'h00, 0, cyc);
    n_cmp++; if (lo8 !== 8'h55) begin n_bad++; $display("FAIL w8_mtlo got %h want 55", lo8); end
    run8(3'd0, 8'h80, 8'h80, 3, cyc);
    n_cmp++; if (cyc !== 14) begin n_bad++; $display("FAIL w8_en_cycles got %0d want 14", cyc); end
    n_cmp++; if (hi8 !== 8'h40 || lo8 !== 8'h00) begin n_bad++; $display("FAIL w8_en_mult got %h/%h want 40/00", hi8, lo8); end
    op8 = 3'd6; #1;
    n_cmp++; if (rd8 !== 8'h40 || stall8 !== 1'b0) begin n_bad++; $display("FAIL w8_mfhi got %h stall %b want 40 stall 0", rd8, stall8); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
    en8 = 1'b1; start8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0; flush8 = 1'b0;
    test_reset;
    test_arith;
    test_stall;
    test_mt;
    test_flush;
    test_reset_midop;
    test_w8;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
